// File: rtl/alu_reservation_station_if.sv
// alu_reservation_station_if
//   Groups the reservation station's bus-level signals so the station and its
//   environment share a single bundle.
//   - dispatch side : disp_rs_* in, rs_disp_full_out back to the dispatcher
//   - broadcast side: alu/lsb CDB tag + result, snooped for operand wakeup
//   - issue side    : registered rs_alu_* bus consumed by the ALU
//   modport slave  = the reservation station
//   modport master = the environment (dispatcher, CDBs, ALU)
interface alu_reservation_station_if #(
  parameter int ID_WIDTH   = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 6
) ();
  logic                  disp_rs_valid_in;
  logic [OP_WIDTH-1:0]   disp_rs_opcode_in;
  logic [ROB_WIDTH-1:0]  disp_rs_qj_in;
  logic [ROB_WIDTH-1:0]  disp_rs_qk_in;
  logic [ID_WIDTH-1:0]   disp_rs_vj_in;
  logic [ID_WIDTH-1:0]   disp_rs_vk_in;
  logic [ID_WIDTH-1:0]   disp_rs_a_in;
  logic [ADDR_WIDTH-1:0] disp_rs_pc_in;
  logic [ROB_WIDTH-1:0]  disp_rs_dest_in;
  logic                  rs_disp_full_out;

  logic [ROB_WIDTH-1:0]  alu_cdb_h_in;
  logic [ID_WIDTH-1:0]   alu_cdb_result_in;
  logic [ROB_WIDTH-1:0]  lsb_cdb_h_in;
  logic [ID_WIDTH-1:0]   lsb_cdb_result_in;

  logic [OP_WIDTH-1:0]   rs_alu_opcode_out;
  logic [ID_WIDTH-1:0]   rs_alu_vj_out;
  logic [ID_WIDTH-1:0]   rs_alu_vk_out;
  logic [ID_WIDTH-1:0]   rs_alu_a_out;
  logic [ADDR_WIDTH-1:0] rs_alu_pc_out;
  logic [ROB_WIDTH-1:0]  rs_alu_dest_out;

  modport slave (
    input  disp_rs_valid_in, disp_rs_opcode_in, disp_rs_qj_in, disp_rs_qk_in,
           disp_rs_vj_in, disp_rs_vk_in, disp_rs_a_in, disp_rs_pc_in, disp_rs_dest_in,
           alu_cdb_h_in, alu_cdb_result_in, lsb_cdb_h_in, lsb_cdb_result_in,
    output rs_disp_full_out, rs_alu_opcode_out, rs_alu_vj_out, rs_alu_vk_out,
           rs_alu_a_out, rs_alu_pc_out, rs_alu_dest_out
  );

  modport master (
    output disp_rs_valid_in, disp_rs_opcode_in, disp_rs_qj_in, disp_rs_qk_in,
           disp_rs_vj_in, disp_rs_vk_in, disp_rs_a_in, disp_rs_pc_in, disp_rs_dest_in,
           alu_cdb_h_in, alu_cdb_result_in, lsb_cdb_h_in, lsb_cdb_result_in,
    input  rs_disp_full_out, rs_alu_opcode_out, rs_alu_vj_out, rs_alu_vk_out,
           rs_alu_a_out, rs_alu_pc_out, rs_alu_dest_out
  );
endinterface

// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Issue-side buffer in front of the ALU. Holds dispatched micro-ops until
//   both operands are valid, wakes operands from the ALU and LSB broadcast
//   buses, and issues the lowest-index ready entry each cycle onto a
//   registered issue bus.
//   Ports:
//     clk_in        rising-edge clock
//     rst_n_in      asynchronous active-low reset
//     rdy_in        global ready; low freezes all state and outputs
//     rob_rs_rst_in synchronous flush from the ROB (mispredict)
//     bus_if        dispatch / broadcast / issue bundle (slave side)

// alu_rs_entry
//   One station slot. Operand tags are matched against both broadcast buses
//   on every edge; the same match also applies to operands arriving with a
//   dispatch, which gives the same-cycle dispatch bypass for free.
//   Ports: en_i (global ready), flush_i, wr_i (dispatch into this slot),
//   iss_i (issued this edge), op/qj/vj/qk/vk/a/pc/dest_i (dispatch fields),
//   alu/lsb_h_i/v_i (broadcast), busy_o, ready_o and stored fields out.
module alu_rs_entry #(
  parameter int ID_WIDTH   = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic                  iss_i,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [ROB_WIDTH-1:0]  qj_i,
  input  logic [ID_WIDTH-1:0]   vj_i,
  input  logic [ROB_WIDTH-1:0]  qk_i,
  input  logic [ID_WIDTH-1:0]   vk_i,
  input  logic [ID_WIDTH-1:0]   a_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ROB_WIDTH-1:0]  dest_i,
  input  logic [ROB_WIDTH-1:0]  alu_h_i,
  input  logic [ID_WIDTH-1:0]   alu_v_i,
  input  logic [ROB_WIDTH-1:0]  lsb_h_i,
  input  logic [ID_WIDTH-1:0]   lsb_v_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [OP_WIDTH-1:0]   op_o,
  output logic [ID_WIDTH-1:0]   vj_o,
  output logic [ID_WIDTH-1:0]   vk_o,
  output logic [ID_WIDTH-1:0]   a_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ROB_WIDTH-1:0]  dest_o
);
  logic                  busy_q, busy_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [ROB_WIDTH-1:0]  qj_q, qj_d, qk_q, qk_d, dest_q, dest_d;
  logic [ID_WIDTH-1:0]   vj_q, vj_d, vk_q, vk_d, a_q, a_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    a_d    = a_q;
    pc_d   = pc_q;
    dest_d = dest_q;
    // operand source: fresh dispatch or stored state, then snoop both buses
    qj_d   = wr_i ? qj_i : qj_q;
    vj_d   = wr_i ? vj_i : vj_q;
    qk_d   = wr_i ? qk_i : qk_q;
    vk_d   = wr_i ? vk_i : vk_q;
    if (qj_d != '0) begin
      if (qj_d == alu_h_i)      begin vj_d = alu_v_i; qj_d = '0; end
      else if (qj_d == lsb_h_i) begin vj_d = lsb_v_i; qj_d = '0; end
    end
    if (qk_d != '0) begin
      if (qk_d == alu_h_i)      begin vk_d = alu_v_i; qk_d = '0; end
      else if (qk_d == lsb_h_i) begin vk_d = lsb_v_i; qk_d = '0; end
    end
    if (iss_i) busy_d = 1'b0;
    if (wr_i) begin
      busy_d = 1'b1;
      op_d   = op_i;
      a_d    = a_i;
      pc_d   = pc_i;
      dest_d = dest_i;
    end
    if (flush_i) busy_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      op_q   <= '0;
      qj_q   <= '0;
      vj_q   <= '0;
      qk_q   <= '0;
      vk_q   <= '0;
      a_q    <= '0;
      pc_q   <= '0;
      dest_q <= '0;
    end else if (en_i) begin
      busy_q <= busy_d;
      op_q   <= op_d;
      qj_q   <= qj_d;
      vj_q   <= vj_d;
      qk_q   <= qk_d;
      vk_q   <= vk_d;
      a_q    <= a_d;
      pc_q   <= pc_d;
      dest_q <= dest_d;
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = busy_q && (qj_q == '0) && (qk_q == '0);
  assign op_o    = op_q;
  assign vj_o    = vj_q;
  assign vk_o    = vk_q;
  assign a_o     = a_q;
  assign pc_o    = pc_q;
  assign dest_o  = dest_q;
endmodule

module alu_reservation_station #(
  parameter int                   RS_SIZE    = 8,
  parameter int                   ID_WIDTH   = 32,
  parameter int                   ROB_WIDTH  = 4,
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   OP_WIDTH   = 6,
  parameter logic [OP_WIDTH-1:0]  OP_NOP     = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     rob_rs_rst_in,
  alu_reservation_station_if.slave bus_if
);
  localparam int                 IDX_W = $clog2(RS_SIZE);
  localparam logic [RS_SIZE-1:0] ONE   = {{(RS_SIZE-1){1'b0}}, 1'b1};

  logic [RS_SIZE-1:0]                 e_busy, e_ready, free_oh, iss_oh, wr_vec;
  logic [RS_SIZE-1:0][OP_WIDTH-1:0]   e_op;
  logic [RS_SIZE-1:0][ID_WIDTH-1:0]   e_vj, e_vk, e_a;
  logic [RS_SIZE-1:0][ADDR_WIDTH-1:0] e_pc;
  logic [RS_SIZE-1:0][ROB_WIDTH-1:0]  e_dest;
  logic                               full, iss_any;
  logic [IDX_W-1:0]                   iss_idx;

  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [ID_WIDTH-1:0]   vj_q, vj_d, vk_q, vk_d, a_q, a_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ROB_WIDTH-1:0]  dest_q, dest_d;

  // full comes from registered busy bits only; a slot issued this edge is
  // still counted, so it cannot be refilled until the following edge
  assign full    = &e_busy;
  // lowest clear bit of busy / lowest set bit of ready
  assign free_oh = ~e_busy & (e_busy + ONE);
  assign iss_oh  = e_ready & (~e_ready + ONE);
  assign iss_any = |e_ready;
  assign wr_vec  = (bus_if.disp_rs_valid_in && !full && !rob_rs_rst_in) ? free_oh : '0;

  always_comb begin
    iss_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (e_ready[i]) iss_idx = i[IDX_W-1:0];
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    alu_rs_entry #(
      .ID_WIDTH(ID_WIDTH), .ROB_WIDTH(ROB_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH), .OP_WIDTH(OP_WIDTH)
    ) u_ent (
      .clk_i   (clk_in),
      .rst_ni  (rst_n_in),
      .en_i    (rdy_in),
      .flush_i (rob_rs_rst_in),
      .wr_i    (wr_vec[g]),
      .iss_i   (iss_oh[g]),
      .op_i    (bus_if.disp_rs_opcode_in),
      .qj_i    (bus_if.disp_rs_qj_in),
      .vj_i    (bus_if.disp_rs_vj_in),
      .qk_i    (bus_if.disp_rs_qk_in),
      .vk_i    (bus_if.disp_rs_vk_in),
      .a_i     (bus_if.disp_rs_a_in),
      .pc_i    (bus_if.disp_rs_pc_in),
      .dest_i  (bus_if.disp_rs_dest_in),
      .alu_h_i (bus_if.alu_cdb_h_in),
      .alu_v_i (bus_if.alu_cdb_result_in),
      .lsb_h_i (bus_if.lsb_cdb_h_in),
      .lsb_v_i (bus_if.lsb_cdb_result_in),
      .busy_o  (e_busy[g]),
      .ready_o (e_ready[g]),
      .op_o    (e_op[g]),
      .vj_o    (e_vj[g]),
      .vk_o    (e_vk[g]),
      .a_o     (e_a[g]),
      .pc_o    (e_pc[g]),
      .dest_o  (e_dest[g])
    );
  end

  // issue register: NOP unless an entry was ready pre-edge and no flush;
  // data fields hold their last value when idle
  always_comb begin
    op_d   = OP_NOP;
    vj_d   = vj_q;
    vk_d   = vk_q;
    a_d    = a_q;
    pc_d   = pc_q;
    dest_d = dest_q;
    if (iss_any && !rob_rs_rst_in) begin
      op_d   = e_op[iss_idx];
      vj_d   = e_vj[iss_idx];
      vk_d   = e_vk[iss_idx];
      a_d    = e_a[iss_idx];
      pc_d   = e_pc[iss_idx];
      dest_d = e_dest[iss_idx];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      op_q   <= OP_NOP;
      vj_q   <= '0;
      vk_q   <= '0;
      a_q    <= '0;
      pc_q   <= '0;
      dest_q <= '0;
    end else if (rdy_in) begin
      op_q   <= op_d;
      vj_q   <= vj_d;
      vk_q   <= vk_d;
      a_q    <= a_d;
      pc_q   <= pc_d;
      dest_q <= dest_d;
    end
  end

  assign bus_if.rs_disp_full_out  = full;
  assign bus_if.rs_alu_opcode_out = op_q;
  assign bus_if.rs_alu_vj_out     = vj_q;
  assign bus_if.rs_alu_vk_out     = vk_q;
  assign bus_if.rs_alu_a_out      = a_q;
  assign bus_if.rs_alu_pc_out     = pc_q;
  assign bus_if.rs_alu_dest_out   = dest_q;
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Issue-side counterpart of the ALU in the Tomasulo core.
- Accepts dispatched integer, branch and jump micro-ops from the dispatcher and holds each until both source operands are valid.
- Wakes operands by snooping the ALU and load/store-buffer broadcast buses, picks one ready entry per cycle, and drives the registered issue bus that the ALU consumes combinationally.
- Flushed by the reorder buffer on mispredict.

Parameters:
RS_SIZE, 8, number of entries (power of two, >=2)
ID_WIDTH, 32, data/immediate width
ROB_WIDTH, 4, ROB tag width; tag 0 reserved as "no tag / no broadcast"
ADDR_WIDTH, 32, PC width
OP_WIDTH, 6, instruction-type code width; NOP code from the shared constant header

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; low freezes all state and outputs
disp_rs_valid_in  in  1  dispatch strobe
disp_rs_opcode_in  in  OP_WIDTH  instruction type
disp_rs_qj_in / disp_rs_qk_in  in  ROB_WIDTH  producer tags; 0 = value already valid
disp_rs_vj_in / disp_rs_vk_in  in  ID_WIDTH  operand values, meaningful when tag is 0
disp_rs_a_in  in  ID_WIDTH  immediate
disp_rs_pc_in  in  ADDR_WIDTH  instruction PC
disp_rs_dest_in  in  ROB_WIDTH  destination ROB tag (nonzero)
rs_disp_full_out  out  1  no free entry
alu_cdb_h_in / lsb_cdb_h_in  in  ROB_WIDTH  broadcast tags; 0 = idle
alu_cdb_result_in / lsb_cdb_result_in  in  ID_WIDTH  broadcast values
rob_rs_rst_in  in  1  synchronous flush
rs_alu_opcode_out  out  OP_WIDTH  issued type; NOP when nothing is issued
rs_alu_vj_out / rs_alu_vk_out  out  ID_WIDTH  issued operands
rs_alu_a_out  out  ID_WIDTH  issued immediate
rs_alu_pc_out  out  ADDR_WIDTH  issued PC
rs_alu_dest_out  out  ROB_WIDTH  issued destination tag

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - All entries invalid.
  - rs_alu_opcode_out = NOP; all other issue outputs 0.
  - rs_disp_full_out = 0.
- Freeze: rdy_in low -> no state change and outputs held. All rules below apply only on edges with rdy_in high.
- Entry fields: busy, opcode, qj, vj, qk, vk, a, pc, dest. An entry is ready when busy, qj==0 and qk==0.
- Full flag: rs_disp_full_out = (busy count == RS_SIZE), decoded from registered state only. It does not account for a same-cycle issue.
- Dispatch:
  - On an edge with disp_rs_valid_in high and not full, write to the lowest-index free entry.
  - Dispatch while full is ignored; the bench flags it as a protocol error.
- Dispatch bypass: if a dispatched qj or qk equals a nonzero broadcast tag in the same cycle, store the broadcast value with tag 0.
- Wakeup:
  - Each edge, every busy entry whose qj/qk equals a nonzero alu_cdb_h_in or lsb_cdb_h_in captures the matching result and clears that tag.
  - Both buses may match different operands of one entry in the same cycle.
- Issue:
  - Each edge, select the lowest-index entry that is ready in registered state (pre-edge).
  - Register its fields onto the rs_alu_* outputs and clear its busy bit.
  - If no entry is ready, rs_alu_opcode_out <= NOP; other outputs are don't-care but held.
- Issue latency:
  - An entry written at edge N is issued no earlier than edge N+1.
  - An operand woken at edge N makes the entry issuable at edge N+1.
  - No same-cycle dispatch-to-issue path.
- Simultaneous issue and dispatch: the freed slot is not reusable until the next edge.
- Flush: rob_rs_rst_in high at an edge ->
  - all busy bits cleared;
  - rs_alu_opcode_out <= NOP;
  - same-cycle dispatch discarded;
  - same-cycle wakeups irrelevant.
- Flush priority: flush has priority over issue and dispatch. Reset has priority over everything.
- Issue width: at most one issue per cycle.

Test Plan:
- Reset then dispatch ADDI (qj=0, vj=5, a=7, dest=3) at edge 1 -> edge 2 outputs opcode=ADDI, vj=5, a=7, dest=3; edge 3 outputs NOP.
- Dispatch ADD (qj=2, qk=0, vk=10, dest=4); ALU broadcast tag 2 with value 0x20 at edge 3 -> issue at edge 4 with vj=0x20, vk=10.
- Dispatch with qj=5 in the same cycle as LSB broadcast tag 5, value 0xFF -> stored ready, issued next edge with vj=0xFF.
- Fill 8 entries all waiting on tag 6 -> full=1 and a 9th dispatch is ignored; broadcast tag 6 -> entries issue one per edge in index order 0..7; full drops after the first issue edge.
- With 3 busy entries, assert rob_rs_rst_in together with a dispatch -> next edge opcode=NOP, full=0, and no later issue of any of these.
- Hold rdy_in low for 3 cycles while a ready entry is present -> outputs unchanged and no issue; issue occurs on the first edge after rdy_in returns high.
